instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the non-pipelined MIPS core and supplies its `instruction` input. It owns the fetch program counter and issues word reads to instruction memory over a req/ack handshake with variable latency. Fetched words go into a small prefetch FIFO, each tagged with its PC. The core drains the FIFO with a valid/ready handshake, and a jump or JR in the core redirects fetch and flushes stale words.

## Interface
- `DEPTH`, default 4: prefetch FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word aligned.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_req`  out  1: read request to instruction memory; registered.
- `mem_addr`  out  32: word address of the request; registered; bits [1:0] always 0.
- `mem_ack`  in  1: memory completes the request in this cycle.
- `mem_rdata`  in  32: read data; valid when `mem_req && mem_ack`.
- `redirect`  in  1: core changed control flow; one-cycle pulse.
- `redirect_pc`  in  32: new fetch address; bits [1:0] are ignored and forced to 0.
- `instr_valid`  out  1: FIFO head is valid.
- `instr`  out  32: FIFO head instruction word.
- `instr_pc`  out  32: PC of the FIFO head word.
- `instr_ready`  in  1: the core accepts the head this cycle.

## Operation
- Transfer rules:
  - A memory transfer happens on a rising edge where `mem_req && mem_ack`.
  - A pop happens on a rising edge where `instr_valid && instr_ready`.
- `mem_req` protocol:
  - Once `mem_req` is high, it and `mem_addr` stay stable until the transfer completes. A request is never retracted.
  - After a transfer, `mem_req` may stay high the next cycle for the next address, giving back-to-back fetches.
- Space test:
  - Let `occ` be the FIFO occupancy after this edge's push and pop are applied.
  - A new request may start only if `occ < DEPTH`. At most one request is in flight, so the in-flight word always has a slot.
- FSM states:
  - IDLE: `mem_req`=0.
    - If `redirect`: load the fetch PC from `redirect_pc`, flush the FIFO, and go to REQ if space allows (after the flush there always is).
    - Otherwise, if space allows: go to REQ with `mem_addr` = fetch PC.
  - REQ: `mem_req`=1.
    - If `redirect` without a transfer: flush the FIFO, load the fetch PC from `redirect_pc`, and go to DISCARD.
    - If `redirect` with a transfer: drop `mem_rdata`, flush the FIFO, and go to REQ with `mem_addr` = `redirect_pc`.
    - If a transfer and no redirect: push {`mem_addr`, `mem_rdata`} and set fetch PC = `mem_addr`+4.
      - If space allows, stay in REQ with the new address.
      - Otherwise go to IDLE.
  - DISCARD: `mem_req`=1, holding the stale address.
    - On a transfer: drop the data and go to REQ with `mem_addr` = fetch PC (the redirect target).
    - A further `redirect` in DISCARD only updates the fetch PC; the state stays DISCARD.
- Redirect priority:
  - `redirect` beats a simultaneous pop and a simultaneous push: the FIFO ends empty.
  - `instr_valid` is 0 in the cycle after any redirect.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- FIFO storage:
  - Circular buffer with read and write pointers plus a count.
  - A simultaneous push and pop when full is legal only if a pop frees the slot. This cannot occur, because the space test already reserves the slot.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - FSM is in IDLE, FIFO is empty, fetch PC=`RESET_PC`.
- `mem_req` rises on the first rising edge after `reset` deasserts.
- Fetch latency:
  - `mem_rdata` acked at edge N appears on `instr`/`instr_valid` after edge N. No combinational path from `mem_rdata` to `instr`.
- `instr`/`instr_pc` come from registered FIFO storage. The head changes only on the edge after a pop or a push into an empty FIFO.
- `instr_ready` has no combinational path to `mem_req`/`mem_addr`.
- Throughput: one word per cycle when memory acks zero-wait and the core accepts every cycle.
- `reset` asserted mid-request abandons the request immediately. Memory must tolerate `mem_req` dropping asynchronously.

## Test plan
- Release reset with `RESET_PC`=0, `mem_ack` tied 1, `instr_ready` tied 1 → `mem_addr` goes 0,4,8,12 on consecutive cycles; `instr_pc` follows one cycle later; `instr` equals the memory model word.
- `instr_ready`=0, `mem_ack`=1, `DEPTH`=4 → exactly 4 transfers, then `mem_req`=0. Raise `instr_ready` → `mem_req` returns and the head stays PC 0.
- Memory with a 3-cycle ack. Pulse `redirect` with `redirect_pc`=32'h0000_0103 during the wait → the stale word is dropped, the next `mem_addr`=32'h0000_0100, and the first word out has `instr_pc`=32'h100.
- `redirect` in the same cycle as `mem_ack` and a pop, with FIFO occupancy 2 → the FIFO is empty next cycle, `mem_addr`=`redirect_pc` with `mem_req`=1, and the acked data never appears.
- Start fetching at `redirect_pc`=32'hFFFF_FFF8 → words tagged FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` while in DISCARD → all outputs take their reset values in the same cycle; after release, fetch resumes at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads imem over req/ack, queues {pc, word} in a prefetch FIFO.
// Latency: an acked word is at the FIFO head one edge later; a full FIFO holds off new requests.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   dat_q [DEPTH];
    logic [31:0]   pc_q  [DEPTH];

    logic          xfer, pop, push, flush, space;
    logic [CW:0]   occ;
    logic [31:0]   redir_pc, next_pc;

    assign redir_pc    = redirect_pc & 32'hFFFF_FFFC;
    assign next_pc     = mem_addr_q + 32'd4;
    assign xfer        = mem_req_q && mem_ack;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = dat_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    mem_addr_d = redir_pc;
                    state_d    = REQ;
                end else if (space) begin
                    mem_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (redirect && !xfer) begin
                    // The request cannot be retracted, so ride it out and drop its data.
                    fetch_pc_d = redir_pc;
                    state_d    = DISCARD;
                end else if (redirect) begin
                    fetch_pc_d = redir_pc;
                    mem_addr_d = redir_pc;
                end else if (xfer) begin
                    fetch_pc_d = next_pc;
                    mem_addr_d = next_pc;
                    if (!space) state_d = IDLE;
                end
            end
            DISCARD: begin
                if (redirect) fetch_pc_d = redir_pc;
                if (xfer) begin
                    mem_addr_d = redirect ? redir_pc : fetch_pc_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush     = redirect;
        push      = (state_q == REQ) && xfer && !redirect;
        occ       = flush ? '0 : ({1'b0, count_q} + (CW+1)'(push) - (CW+1)'(pop));
        space     = occ < (CW+1)'(DEPTH);
        mem_req_d = (state_d != IDLE);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                dat_q[wr_ptr_q] <= mem_rdata;
                pc_q[wr_ptr_q]  <= mem_addr_q;
            end
        end
    end
endmodule
